// File: rtl/anton_neopixel_apb.sv
// ---------------------------------------------------------------------------
// anton_neopixel_apb
//
// APB3 slave bridge that sits directly in front of the neopixel raw
// controller. An APB transfer becomes one single-cycle busWrite/busRead
// strobe toward the controller. Every transfer gets exactly one wait state,
// which gives the controller time to register its read data before PRDATA
// is returned.
//
// Optional feature macro: ANTON_NEOPIXEL_APB_PSLVERR_EN
//   defined   : PSLVERR flags out-of-range buffer accesses and writes to the
//               read-only status register. Erroring writes are not strobed.
//   undefined : PSLVERR is held at 0 and every access is forwarded.
//
// Parameters
//   BUFFER_END  last valid pixel byte index (must match the controller)
//
// Ports
//   busClk      in   bus clock, shared with the controller
//   busReset    in   synchronous active-high reset
//   PSEL        in   APB select
//   PENABLE     in   APB enable (access phase)
//   PWRITE      in   1 = write, 0 = read
//   PADDR       in   [15:0] byte address, [1:0] ignored
//   PWDATA      in   [31:0] write data, only [7:0] forwarded
//   PRDATA      out  [31:0] read data, 0 outside the completion cycle
//   PREADY      out  transfer complete
//   PSLVERR     out  error response
//   busAddr     out  [13:0] controller address, captured in setup
//   busDataIn   out  [7:0] controller write data, captured in setup
//   busWrite    out  one-cycle write strobe
//   busRead     out  one-cycle read strobe
//   busDataOut  in   [7:0] controller registered read data
//
// States
//   IDLE   | waiting for an APB setup phase
//   STROBE | first access cycle, strobe issued to the controller
//   DONE   | second access cycle, PREADY and response returned
// ---------------------------------------------------------------------------
module anton_neopixel_apb #(
    parameter int unsigned BUFFER_END = 31
) (
    input  logic        busClk,
    input  logic        busReset,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [15:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_dir;
    logic        r_err;
    logic [13:0] r_addr;
    logic [7:0]  r_data;

    logic        w_setup;
    logic        w_buf_oob;
    logic        w_status_wr;
    logic        w_err_en;
    logic        w_err;
    logic        w_unused;

`ifdef ANTON_NEOPIXEL_APB_PSLVERR_EN
    assign w_err_en = 1'b1;
`else
    assign w_err_en = 1'b0;
`endif

    // Only the byte lane and the word address reach the controller.
    assign w_unused = ^{PADDR[1:0], PWDATA[31:8]};

    assign w_setup = PSEL && !PENABLE;

    // Error classification is done on the setup-phase address so that the
    // STROBE cycle can already suppress an illegal write.
    assign w_buf_oob   = !PADDR[15] && (32'(PADDR[14:2]) > BUFFER_END);
    assign w_status_wr = PADDR[15] && PWRITE && (PADDR[3:2] == 2'd3);

    assign w_err = r_err && w_err_en;

    always_ff @(posedge busClk) begin
        if (busReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge busClk) begin
        if (busReset) begin
            r_dir  <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (r_state == IDLE && w_setup) begin
            r_dir  <= PWRITE;
            r_err  <= w_buf_oob || w_status_wr;
            r_addr <= PADDR[15:2];
            r_data <= PWDATA[7:0];
        end
    end

    always_comb begin
        w_next   = r_state;
        busWrite = 1'b0;
        busRead  = 1'b0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        PRDATA   = '0;
        case (r_state)
            IDLE: begin
                // A bare PENABLE without a setup phase is ignored.
                if (w_setup) begin
                    w_next = STROBE;
                end
            end
            STROBE: begin
                // Issued even if the master aborted; the controller
                // transaction is already committed.
                busWrite = r_dir && !w_err;
                busRead  = !r_dir;
                w_next   = DONE;
            end
            DONE: begin
                PREADY  = 1'b1;
                PSLVERR = w_err;
                if (!r_dir && !w_err) begin
                    PRDATA = {24'b0, busDataOut};
                end
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign busAddr   = r_addr;
    assign busDataIn = r_data;

endmodule

// File: tb/tb_anton_neopixel_apb.sv
module tb_anton_neopixel_apb;

    localparam int BUF_END = 31;

    logic        busClk = 1'b0;
    logic        busReset;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;

    int n_cmp = 0;
    int n_bad = 0;

    anton_neopixel_apb #(.BUFFER_END(BUF_END)) dut (
        .busClk     (busClk),
        .busReset   (busReset),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .busAddr    (busAddr),
        .busDataIn  (busDataIn),
        .busWrite   (busWrite),
        .busRead    (busRead),
        .busDataOut (busDataOut)
    );

    always #5 busClk = ~busClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Emulated controller: read data registered on the edge that ends the
    // busRead cycle.
    logic [7:0] rd_val = 8'h00;
    logic       saw_rd = 1'b0;
    always @(negedge busClk) saw_rd = busRead;
    always @(posedge busClk) if (saw_rd) busDataOut = rd_val;

    // Transaction-level model: a transfer accepted at a setup edge has its
    // strobe cycle one edge later and its completion cycle two edges later.
    function automatic bit pslverr_expected(input bit wr, input logic [15:0] a);
        int word;
        word = int'(a) / 4;
`ifdef ANTON_NEOPIXEL_APB_PSLVERR_EN
        if (word < 8192) return word > BUF_END;
        return wr && (word % 4 == 3);
`else
        return 1'b0;
`endif
    endfunction

    int          m_age   = -1;   // -1 none, 1 strobe cycle, 2 completion cycle
    bit          m_valid = 1'b0;
    bit          m_wr;
    bit          m_err;
    logic [13:0] m_addr;
    logic [7:0]  m_data;

    always @(posedge busClk) begin
        if (busReset) begin
            m_valid = 1'b1;
            m_age   = -1;
            m_addr  = '0;
            m_data  = '0;
            m_wr    = 1'b0;
            m_err   = 1'b0;
        end else if (m_valid) begin
            if ((m_age == -1 || m_age == 2) && PSEL && !PENABLE) begin
                m_age  = 1;
                m_wr   = PWRITE;
                m_addr = 14'(int'(PADDR) / 4);
                m_data = 8'(PWDATA % 256);
                m_err  = pslverr_expected(PWRITE, PADDR);
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                m_age = -1;
            end
        end
    end

    always @(negedge busClk) begin
        if (m_valid) begin
            check("busWrite", 32'(busWrite), 32'(m_age == 1 && m_wr && !m_err));
            check("busRead",  32'(busRead),  32'(m_age == 1 && !m_wr));
            check("PREADY",   32'(PREADY),   32'(m_age == 2));
            check("PSLVERR",  32'(PSLVERR),  32'(m_age == 2 && m_err));
            check("PRDATA",   PRDATA, (m_age == 2 && !m_wr && !m_err) ? 32'(busDataOut) : 32'h0);
            check("busAddr",  32'(busAddr),  32'(m_addr));
            check("busDataIn",32'(busDataIn),32'(m_data));
        end
    end

    // One APB transfer; returns the values seen in the strobe and completion
    // cycles and the cycle count from setup to completion inclusive.
    task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                        output logic s_wr, output logic s_rd, output logic [13:0] s_addr,
                        output logic [7:0] s_din, output logic [31:0] rdata,
                        output logic err, output int cyc);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        cyc = 1;
        @(posedge busClk); #1;
        PENABLE = 1'b1;
        cyc++;
        s_wr = busWrite; s_rd = busRead; s_addr = busAddr; s_din = busDataIn;
        while (!PREADY && cyc < 6) begin
            @(posedge busClk); #1;
            cyc++;
        end
        if (!PREADY) check("xfer_timeout", 32'(PREADY), 32'h1);
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge busClk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic        s_wr, s_rd, err;
    logic [13:0] s_addr;
    logic [7:0]  s_din;
    logic [31:0] rdata;
    int          cyc, cyc2;

    initial begin
        busReset = 1'b1; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 16'h0004; PWDATA = 32'h55; busDataOut = 8'h00;

        // 1: reset held two cycles with PSEL high
        repeat (2) @(posedge busClk);
        #1;
        check("rst_PREADY",   32'(PREADY),   32'h0);
        check("rst_busWrite", 32'(busWrite), 32'h0);
        check("rst_busAddr",  32'(busAddr),  32'h0);
        check("rst_PRDATA",   PRDATA,        32'h0);
        busReset = 1'b0;

        // 2: write, first setup right after reset release
        xfer(1'b1, 16'h0014, 32'hDEADBEA5, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
        check("t2_busWrite",  32'(s_wr),   32'h1);
        check("t2_busRead",   32'(s_rd),   32'h0);
        check("t2_busAddr",   32'(s_addr), 32'h5);
        check("t2_busDataIn", 32'(s_din),  32'hA5);
        check("t2_cycles",    32'(cyc),    32'd3);
        check("t2_PRDATA",    rdata,       32'h0);

        // idle cycle with a bare PENABLE: must be ignored
        PSEL = 1'b1; PENABLE = 1'b1;
        repeat (2) @(posedge busClk);
        #1;
        check("bare_en_PREADY", 32'(PREADY), 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge busClk); #1;

        // 3: register-bank read
        rd_val = 8'h1F;
        xfer(1'b0, 16'h8008, 32'h0, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
        check("t3_busAddr", 32'(s_addr), 32'h2002);
        check("t3_busRead", 32'(s_rd),   32'h1);
        check("t3_busWrite",32'(s_wr),   32'h0);
        check("t3_PRDATA",  rdata,       32'h0000001F);

        // 4: back-to-back write then read, no idle cycle
        rd_val = 8'h3C;
        xfer(1'b1, 16'h0008, 32'h00000077, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
        xfer(1'b0, 16'h0010, 32'h0, s_wr, s_rd, s_addr, s_din, rdata, err, cyc2);
        check("t4_total_cycles", 32'(cyc + cyc2), 32'd6);
        check("t4_PRDATA",       rdata,           32'h3C);
        check("t4_busAddr",      32'(s_addr),     32'h4);

        // 5: reset during the STROBE cycle of a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0018; PWDATA = 32'h11;
        @(posedge busClk); #1;
        PENABLE = 1'b1;
        check("t5_strobe", 32'(busWrite), 32'h1);
        busReset = 1'b1;
        @(posedge busClk); #1;
        check("t5_busWrite", 32'(busWrite), 32'h0);
        check("t5_PREADY",   32'(PREADY),   32'h0);
        busReset = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) @(posedge busClk);
        #1;
        check("t5_PREADY_late", 32'(PREADY), 32'h0);

        // 6: error decode
        xfer(1'b1, 16'h0080, 32'h99, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
`ifdef ANTON_NEOPIXEL_APB_PSLVERR_EN
        check("t6_idx32_err",   32'(err),  32'h1);
        check("t6_idx32_wr",    32'(s_wr), 32'h0);
`else
        check("t6_idx32_err",   32'(err),  32'h0);
        check("t6_idx32_wr",    32'(s_wr), 32'h1);
`endif
        check("t6_idx32_cycles", 32'(cyc), 32'd3);
        xfer(1'b1, 16'h007C, 32'h98, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
        check("t6_idx31_err", 32'(err),  32'h0);
        check("t6_idx31_wr",  32'(s_wr), 32'h1);
        rd_val = 8'hC3;
        xfer(1'b1, 16'h800C, 32'h01, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
`ifdef ANTON_NEOPIXEL_APB_PSLVERR_EN
        check("t6_status_wr_err", 32'(err), 32'h1);
`else
        check("t6_status_wr_err", 32'(err), 32'h0);
`endif
        xfer(1'b0, 16'h800C, 32'h0, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
        check("t6_status_rd_err", 32'(err),  32'h0);
        check("t6_status_rd_data", rdata,    32'hC3);
        xfer(1'b0, 16'h0100, 32'h0, s_wr, s_rd, s_addr, s_din, rdata, err, cyc);
        check("t6_oob_rd_strobe", 32'(s_rd), 32'h1);
`ifdef ANTON_NEOPIXEL_APB_PSLVERR_EN
        check("t6_oob_rd_data", rdata, 32'h0);
`else
        check("t6_oob_rd_data", rdata, 32'hC3);
`endif

        repeat (3) @(posedge busClk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
